atm_ledger_arbiter: RTL and testbench

//  Shares one on-chip account-balance ledger between N_REQ ATM session controllers.

---
 rtl/atm_ledger_arbiter_pkg.sv | 22 ++
 rtl/atm_rr_arbiter.sv | 28 ++
 rtl/atm_ledger_arbiter.sv | 153 +++++++++++++++
 tb/tb_atm_ledger_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_ledger_arbiter_pkg.sv
// Shared encodings for the ATM ledger arbiter: op codes, response status codes and FSM states.
// The ATM session controller uses the same op codes.
package atm_ledger_arbiter_pkg;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_DEP  = 3'b001;
    localparam logic [2:0] OP_WDR  = 3'b010;
    localparam logic [2:0] OP_BAL  = 3'b011;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_INSUF = 2'b01;
    localparam logic [1:0] ST_OVF   = 2'b10;
    localparam logic [1:0] ST_BADOP = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StExec,
        StResp
    } state_e;

endpackage

// File: rtl/atm_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after the pointer.
module atm_rr_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] gnt_o
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = PTR_W'((32'(ptr_i) + k) % N_REQ);
            if (en_i && !found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/atm_ledger_arbiter.sv
// Shares one account-balance ledger between N_REQ ATM sessions; each granted transaction
// runs read -> check -> write-back atomically under round-robin arbitration.
module atm_ledger_arbiter
    import atm_ledger_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ    = 2,
    parameter int unsigned IDX_W    = 2,
    parameter int unsigned AMT_W    = 5,
    parameter int unsigned BAL_W    = 5,
    parameter int unsigned INIT_BAL = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [3*N_REQ-1:0]     req_op,
    input  logic [IDX_W*N_REQ-1:0] req_acct,
    input  logic [AMT_W*N_REQ-1:0] req_amount,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [1:0]             rsp_status,
    output logic [BAL_W-1:0]       rsp_balance
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned NACCT = 2 ** IDX_W;
    localparam int unsigned CW    = ((AMT_W > BAL_W) ? AMT_W : BAL_W) + 1;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, gnt_q, gnt_idx;
    logic [2:0]       op_q, op_sel;
    logic [IDX_W-1:0] acct_q, acct_sel;
    logic [AMT_W-1:0] amt_q, amt_sel;
    logic [BAL_W-1:0] bal_q;
    logic [BAL_W-1:0] ledger_q [NACCT];
    logic [1:0]       rsp_status_q, exec_status;
    logic [BAL_W-1:0] rsp_balance_q, exec_bal;
    logic             exec_wr;
    logic [CW-1:0]    bal_ext, amt_ext, sum_ext;
    logic             xfer;

    atm_rr_arbiter #(
        .N_REQ(N_REQ),
        .PTR_W(PTR_W)
    ) u_rr (
        .req_i(req_valid),
        .ptr_i(ptr_q),
        .en_i (state_q == StIdle),
        .gnt_o(req_ready)
    );

    assign xfer        = |req_ready;
    assign rsp_status  = rsp_status_q;
    assign rsp_balance = rsp_balance_q;

    always_comb begin
        gnt_idx  = '0;
        op_sel   = '0;
        acct_sel = '0;
        amt_sel  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                gnt_idx  = PTR_W'(i);
                op_sel   = req_op[3*i +: 3];
                acct_sel = req_acct[IDX_W*i +: IDX_W];
                amt_sel  = req_amount[AMT_W*i +: AMT_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (xfer) state_d = StRead;
            StRead:  state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Widened arithmetic so a deposit carry and an over-withdraw are both visible.
    always_comb begin
        bal_ext     = CW'(bal_q);
        amt_ext     = CW'(amt_q);
        sum_ext     = bal_ext + amt_ext;
        exec_status = ST_OK;
        exec_bal    = bal_q;
        exec_wr     = 1'b0;
        case (op_q)
            OP_DEP: begin
                if (|sum_ext[CW-1:BAL_W]) begin
                    exec_status = ST_OVF;
                end else begin
                    exec_bal = sum_ext[BAL_W-1:0];
                    exec_wr  = 1'b1;
                end
            end
            OP_WDR: begin
                if (amt_ext > bal_ext) begin
                    exec_status = ST_INSUF;
                end else begin
                    exec_bal = bal_q - amt_ext[BAL_W-1:0];
                    exec_wr  = 1'b1;
                end
            end
            OP_BAL:  exec_status = ST_OK;
            OP_NONE: exec_status = ST_BADOP;
            default: exec_status = ST_BADOP;
        endcase
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == StResp) rsp_valid[gnt_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q         <= '0;
            gnt_q         <= '0;
            op_q          <= '0;
            acct_q        <= '0;
            amt_q         <= '0;
            bal_q         <= '0;
            rsp_status_q  <= ST_OK;
            rsp_balance_q <= '0;
            for (int unsigned i = 0; i < NACCT; i++) ledger_q[i] <= BAL_W'(INIT_BAL);
        end else begin
            if (state_q == StIdle && xfer) begin
                gnt_q  <= gnt_idx;
                op_q   <= op_sel;
                acct_q <= acct_sel;
                amt_q  <= amt_sel;
            end
            if (state_q == StRead) bal_q <= ledger_q[acct_q];
            // The write lands on the same edge that enters RESP, so the next read sees it.
            if (state_q == StExec) begin
                rsp_status_q  <= exec_status;
                rsp_balance_q <= exec_bal;
                if (exec_wr) ledger_q[acct_q] <= exec_bal;
            end
            if (state_q == StResp) begin
                ptr_q <= (gnt_q == PTR_W'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Self-checking bench: reference ledger model predicts grants and responses into a scoreboard
// queue; an independent monitor compares each DUT response against the queued expectation.
module tb_atm_ledger_arbiter;

    localparam int N_REQ    = 2;
    localparam int IDX_W    = 2;
    localparam int AMT_W    = 5;
    localparam int BAL_W    = 5;
    localparam int INIT_BAL = 0;
    localparam int MAXBAL   = (1 << BAL_W) - 1;
    localparam int NACCT    = 1 << IDX_W;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N_REQ-1:0]       req_valid = '0;
    logic [N_REQ-1:0]       req_ready;
    logic [3*N_REQ-1:0]     req_op = '0;
    logic [IDX_W*N_REQ-1:0] req_acct = '0;
    logic [AMT_W*N_REQ-1:0] req_amount = '0;
    logic [N_REQ-1:0]       rsp_valid;
    logic [1:0]             rsp_status;
    logic [BAL_W-1:0]       rsp_balance;

    atm_ledger_arbiter #(
        .N_REQ   (N_REQ),
        .IDX_W   (IDX_W),
        .AMT_W   (AMT_W),
        .BAL_W   (BAL_W),
        .INIT_BAL(INIT_BAL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_acct   (req_acct),
        .req_amount (req_amount),
        .rsp_valid  (rsp_valid),
        .rsp_status (rsp_status),
        .rsp_balance(rsp_balance)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int idx; int st; int bal; int due;} exp_t;
    typedef struct {int vld; int st; int bal;} rsp_t;
    exp_t sb_q[$];
    rsp_t log_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one transaction in flight, 4 cycles each, round-robin winner.
    int m_led[NACCT];
    int m_ptr  = 0;
    int m_busy = 0;

    always @(negedge clk) begin : tracker
        logic [N_REQ-1:0] exp_rdy;
        int w, c, op, acct, amt, bal, st, nb;
        if (rst) begin
            for (int a = 0; a < NACCT; a++) m_led[a] = INIT_BAL;
            m_ptr  = 0;
            m_busy = 0;
        end else begin
            exp_rdy = '0;
            w = -1;
            if (m_busy > 0) begin
                m_busy--;
            end else begin
                for (int k = 0; k < N_REQ; k++) begin
                    c = (m_ptr + k) % N_REQ;
                    if (w < 0 && req_valid[c]) w = c;
                end
            end
            if (w >= 0) exp_rdy[w] = 1'b1;
            chk("req_ready", int'(req_ready), int'(exp_rdy));
            if (w >= 0) begin
                op   = int'(req_op[3*w +: 3]);
                acct = int'(req_acct[IDX_W*w +: IDX_W]);
                amt  = int'(req_amount[AMT_W*w +: AMT_W]);
                bal  = m_led[acct];
                nb   = bal;
                case (op)
                    1: if (bal + amt > MAXBAL) st = 2; else begin st = 0; nb = bal + amt; end
                    2: if (amt > bal) st = 1; else begin st = 0; nb = bal - amt; end
                    3: st = 0;
                    default: st = 3;
                endcase
                m_led[acct] = nb;
                sb_q.push_back('{idx: w, st: st, bal: nb, due: cyc + 3});
                m_busy = 3;
                m_ptr  = (w + 1) % N_REQ;
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            sb_q.delete();
        end else if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            chk("rsp_valid", int'(rsp_valid), 1 << e.idx);
            chk("rsp_status", int'(rsp_status), e.st);
            chk("rsp_balance", int'(rsp_balance), e.bal);
            log_q.push_back('{vld: int'(rsp_valid), st: int'(rsp_status), bal: int'(rsp_balance)});
        end else if (rsp_valid != '0) begin
            chk("rsp_unexpected", int'(rsp_valid), 0);
        end
    end

    task automatic issue(input int r, input int op, input int acct, input int amt);
        bit granted = 0;
        @(posedge clk);
        #1;
        req_op[3*r +: 3]             = 3'(op);
        req_acct[IDX_W*r +: IDX_W]   = IDX_W'(acct);
        req_amount[AMT_W*r +: AMT_W] = AMT_W'(amt);
        req_valid[r]                 = 1'b1;
        for (int k = 0; k < 60 && !granted; k++) begin
            @(negedge clk);
            if (req_ready[r]) granted = 1;
        end
        if (granted) @(posedge clk);
        else chk("grant_timeout", int'(req_ready[r]), 1);
        #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb_q.size() != 0 && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("drain", sb_q.size(), 0);
    endtask

    task automatic run(input string name, input int r, input int op, input int acct,
                       input int amt, input int exp_st, input int exp_bal);
        log_q.delete();
        issue(r, op, acct, amt);
        drain();
        chk({name, "_count"}, log_q.size(), 1);
        if (log_q.size() > 0) begin
            chk({name, "_vld"}, log_q[0].vld, 1 << r);
            chk({name, "_status"}, log_q[0].st, exp_st);
            chk({name, "_balance"}, log_q[0].bal, exp_bal);
        end
    endtask

    task automatic rand_req(input int r);
        int sel, op;
        for (int n = 0; n < 15; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4)       op = 1;
            else if (sel < 7)  op = 2;
            else if (sel == 7) op = 3;
            else if (sel == 8) op = 0;
            else               op = $urandom_range(4, 7);
            issue(r, op, $urandom_range(0, NACCT - 1), $urandom_range(0, MAXBAL));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", int'(req_ready), 0);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_status", int'(rsp_status), 0);
        chk("reset_rsp_balance", int'(rsp_balance), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        run("dep7", 0, 1, 1, 7, 0, 7);
        run("wdr_all", 0, 2, 1, 7, 0, 0);
        run("wdr_insuf", 0, 2, 1, 1, 1, 0);
        run("bal_after_insuf", 1, 3, 1, 0, 0, 0);

        run("dep30", 0, 1, 2, 30, 0, 30);
        run("dep_ovf", 0, 1, 2, 5, 2, 30);
        run("bal30", 1, 3, 2, 0, 0, 30);
        run("dep_zero", 0, 1, 2, 0, 0, 30);
        run("wdr_zero", 1, 2, 2, 0, 0, 30);

        // Both requesters continuously busy; pointer is 0 here, so grants go 0,1,0,1...
        log_q.delete();
        fork
            begin for (int n = 0; n < 4; n++) issue(0, 1, 3, 1); end
            begin for (int n = 0; n < 4; n++) issue(1, 3, 3, 0); end
        join
        drain();
        chk("rr_count", log_q.size(), 8);
        for (int k = 0; k < log_q.size(); k++) chk("rr_order", log_q[k].vld, (k % 2 == 0) ? 1 : 2);

        run("setup_acct0", 1, 1, 0, 4, 0, 4);
        log_q.delete();
        fork
            issue(0, 1, 0, 3);
            issue(1, 2, 0, 2);
        join
        drain();
        chk("simul_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("simul_first_vld", log_q[0].vld, 1);
            chk("simul_first_bal", log_q[0].bal, 7);
            chk("simul_second_vld", log_q[1].vld, 2);
            chk("simul_second_bal", log_q[1].bal, 5);
        end
        run("acct0_final", 0, 3, 0, 0, 0, 5);

        // Reset while a deposit is in EXEC: no write, no response.
        issue(0, 1, 3, 4);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("abort_rsp_valid", int'(rsp_valid), 0);
        end
        run("acct3_after_abort", 1, 3, 3, 0, 0, INIT_BAL);
        run("dep_after_abort", 0, 1, 3, 9, 0, INIT_BAL + 9);
        run("badop_000", 1, 0, 3, 5, 3, INIT_BAL + 9);
        run("badop_1xx", 0, 6, 3, 5, 3, INIT_BAL + 9);

        fork
            rand_req(0);
            rand_req(1);
        join
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
